// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad entry block.
// Key codes double as digit values so digit keys can be written straight to the display.
package keypad_pkg;

    typedef enum logic [2:0] {
        StScan,
        StDebounce,
        StPress,
        StClear,
        StRelease
    } state_e;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam logic [3:0] DIG_IDLE = 4'hF;
    localparam int unsigned NUM_POS = 8;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= KEY_9;
    endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational keypad lookup: active column index plus row lines to a key code.
// When several rows are low the lowest row index wins.
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [1:0] col_i,
    input  logic [3:0] row_n_i,
    output logic       valid_o,
    output logic [3:0] key_o
);

    logic [1:0] row;

    always_comb begin
        valid_o = ~&row_n_i;
        row     = 2'd3;
        if (!row_n_i[0]) begin
            row = 2'd0;
        end else if (!row_n_i[1]) begin
            row = 2'd1;
        end else if (!row_n_i[2]) begin
            row = 2'd2;
        end
    end

    always_comb begin
        key_o = KEY_D;
        unique case ({row, col_i})
            4'b00_00: key_o = KEY_1;
            4'b00_01: key_o = KEY_2;
            4'b00_10: key_o = KEY_3;
            4'b00_11: key_o = KEY_A;
            4'b01_00: key_o = KEY_4;
            4'b01_01: key_o = KEY_5;
            4'b01_10: key_o = KEY_6;
            4'b01_11: key_o = KEY_B;
            4'b10_00: key_o = KEY_7;
            4'b10_01: key_o = KEY_8;
            4'b10_10: key_o = KEY_9;
            4'b10_11: key_o = KEY_C;
            4'b11_00: key_o = KEY_STAR;
            4'b11_01: key_o = KEY_0;
            4'b11_10: key_o = KEY_HASH;
            4'b11_11: key_o = KEY_D;
        endcase
    end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce that turns digit keys into (dig, pos) display writes
// and maintains an auto-advancing cursor; 'A' clears all eight positions.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [3:0] row_n_i,
    output logic [3:0] col_n_o,
    output logic [3:0] dig_o,
    output logic [3:0] pos_o,
    output logic       wr_o
);

    localparam int unsigned TickW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW  = $clog2(DEBOUNCE + 1);
    localparam logic [TickW-1:0] TickMax = TickW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0]  CntMax  = CntW'(DEBOUNCE);

    state_e           state_q, state_d;
    logic [3:0]       row_meta_q, row_sync_q;
    logic [TickW-1:0] tick_q, tick_d;
    logic [3:0]       col_n_q, col_n_d;
    logic [CntW-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]       key_q, key_d;
    logic [2:0]       cursor_q, cursor_d;
    logic [2:0]       clr_q, clr_d;
    logic [3:0]       dig_q, dig_d;
    logic [3:0]       pos_q, pos_d;
    logic             wr_q, wr_d;

    logic       tick;
    logic [1:0] col_idx;
    logic [3:0] col_rot;
    logic       key_valid;
    logic [3:0] key_code;

    assign tick    = (tick_q == TickMax);
    assign tick_d  = tick ? '0 : tick_q + TickW'(1);
    assign col_rot = {col_n_q[2:0], col_n_q[3]};

    always_comb begin
        col_idx = 2'd0;
        unique case (col_n_q)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    keypad_decode u_decode (
        .col_i   (col_idx),
        .row_n_i (row_sync_q),
        .valid_o (key_valid),
        .key_o   (key_code)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            tick_q     <= '0;
            state_q    <= StScan;
            col_n_q    <= 4'b1110;
            db_cnt_q   <= '0;
            key_q      <= KEY_0;
            cursor_q   <= '0;
            clr_q      <= '0;
            dig_q      <= DIG_IDLE;
            pos_q      <= '0;
            wr_q       <= 1'b0;
        end else begin
            row_meta_q <= row_n_i;
            row_sync_q <= row_meta_q;
            tick_q     <= tick_d;
            state_q    <= state_d;
            col_n_q    <= col_n_d;
            db_cnt_q   <= db_cnt_d;
            key_q      <= key_d;
            cursor_q   <= cursor_d;
            clr_q      <= clr_d;
            dig_q      <= dig_d;
            pos_q      <= pos_d;
            wr_q       <= wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_n_d  = col_n_q;
        db_cnt_d = db_cnt_q;
        key_d    = key_q;
        cursor_d = cursor_q;
        clr_d    = clr_q;
        unique case (state_q)
            StScan: begin
                if (tick) begin
                    if (key_valid) begin
                        key_d    = key_code;
                        db_cnt_d = CntW'(1);
                        state_d  = (DEBOUNCE == 1) ? StPress : StDebounce;
                    end else begin
                        col_n_d = col_rot;
                    end
                end
            end
            StDebounce: begin
                if (tick) begin
                    if (key_valid && key_code == key_q) begin
                        db_cnt_d = db_cnt_q + CntW'(1);
                        if (db_cnt_d == CntMax) begin
                            state_d = StPress;
                        end
                    end else begin
                        state_d  = StScan;
                        col_n_d  = col_rot;
                        db_cnt_d = '0;
                    end
                end
            end
            StPress: begin
                db_cnt_d = '0;
                state_d  = StRelease;
                if (is_digit(key_q)) begin
                    cursor_d = cursor_q + 3'd1;
                end else if (key_q == KEY_HASH) begin
                    cursor_d = cursor_q - 3'd1;
                end else if (key_q == KEY_STAR) begin
                    cursor_d = '0;
                end else if (key_q == KEY_A) begin
                    clr_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                clr_d = clr_q + 3'd1;
                if (clr_q == 3'(NUM_POS - 1)) begin
                    cursor_d = '0;
                    state_d  = StRelease;
                end
            end
            StRelease: begin
                // Release needs DEBOUNCE consecutive all-high samples; any low sample restarts.
                if (tick) begin
                    if (&row_sync_q) begin
                        db_cnt_d = db_cnt_q + CntW'(1);
                        if (db_cnt_d == CntMax) begin
                            db_cnt_d = '0;
                            state_d  = StScan;
                            col_n_d  = col_rot;
                        end
                    end else begin
                        db_cnt_d = '0;
                    end
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_comb begin
        dig_d = DIG_IDLE;
        pos_d = {1'b0, cursor_q};
        wr_d  = 1'b0;
        if (state_q == StPress && is_digit(key_q)) begin
            dig_d = key_q;
            wr_d  = 1'b1;
        end else if (state_q == StClear) begin
            dig_d = KEY_0;
            pos_d = {1'b0, clr_q};
            wr_d  = 1'b1;
        end
    end

    assign col_n_o = col_n_q;
    assign dig_o   = dig_q;
    assign pos_o   = pos_q;
    assign wr_o    = wr_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a key-vector table, hand-timed bounce/priority/reset sequences,
// and random key presses checked against a cursor-and-write model.
module tb_keypad_entry;

    typedef struct {
        int row;
        int col;
        int hold;
        int n_wr;
        int dig;
        int pos;
        int cur;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] dig;
    logic [3:0] pos;
    logic       wr;
    logic [15:0] keys;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int n_checks;
    int n_pass;
    int inv_bad;
    int keymap[16];

    keypad_entry #(
        .SCAN_DIV (4),
        .DEBOUNCE (2)
    ) dut (
        .clock_i (clk),
        .reset_i (reset),
        .row_n_i (row_n),
        .col_n_o (col_n),
        .dig_o   (dig),
        .pos_o   (pos),
        .wr_o    (wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && wr) got.push_back({dig, pos});
        if (wr != (dig < 4'd10)) inv_bad++;
        if (pos > 4'd7) inv_bad++;
        if (!(col_n == 4'b1110 || col_n == 4'b1101 || col_n == 4'b1011 || col_n == 4'b0111))
            inv_bad++;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic press(input int r, input int c, input int hold, input int rel);
        got.delete();
        keys = 16'h0;
        keys[r*4+c] = 1'b1;
        repeat (hold) @(negedge clk);
        keys = 16'h0;
        repeat (rel) @(negedge clk);
    endtask

    // Ends at the first negedge after the scan has just moved onto column 0.
    task automatic wait_col0(output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (col_n == 4'b1110 && n < 60) begin
            @(negedge clk);
            n++;
        end
        while (col_n != 4'b1110 && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 60);
    endtask

    vec_t tbl[25];
    logic [3:0] exp_col[5];

    initial begin
        int t;
        int cur;
        int k;
        int code;
        int nw;
        bit ok;
        bit found;

        n_checks = 0;
        n_pass   = 0;
        inv_bad  = 0;
        keys     = 16'h0;
        keymap   = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
        exp_col  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        t = 0;
        for (int i = 0; i < 9; i++) begin
            tbl[t] = '{0, 0, 40, 1, 1, i % 8, (i + 1) % 8};
            t++;
        end
        tbl[t] = '{3, 2, 40, 0, 0, 0, 0}; t++;  // '#'
        tbl[t] = '{3, 2, 40, 0, 0, 0, 7}; t++;  // '#'
        tbl[t] = '{3, 0, 40, 0, 0, 0, 0}; t++;  // '*'
        tbl[t] = '{1, 1, 120, 1, 5, 0, 1}; t++; // '5', long hold
        tbl[t] = '{0, 1, 40, 1, 2, 1, 2}; t++;
        tbl[t] = '{0, 2, 40, 1, 3, 2, 3}; t++;
        tbl[t] = '{0, 3, 40, 8, 0, 0, 0}; t++;  // 'A'
        tbl[t] = '{1, 3, 40, 0, 0, 0, 0}; t++;  // 'B'
        tbl[t] = '{2, 3, 40, 0, 0, 0, 0}; t++;  // 'C'
        tbl[t] = '{3, 3, 40, 0, 0, 0, 0}; t++;  // 'D'
        tbl[t] = '{3, 1, 40, 1, 0, 0, 1}; t++;
        tbl[t] = '{2, 2, 40, 1, 9, 1, 2}; t++;
        tbl[t] = '{1, 2, 40, 1, 6, 2, 3}; t++;
        tbl[t] = '{1, 0, 40, 1, 4, 3, 4}; t++;
        tbl[t] = '{2, 1, 40, 1, 8, 4, 5}; t++;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_col_n", int'(col_n), 14);
        check("reset_dig", int'(dig), 15);
        check("reset_pos", int'(pos), 0);
        check("reset_wr", int'(wr), 0);
        reset = 1'b0;

        @(negedge clk);
        check("col_rot_0", int'(col_n), int'(exp_col[0]));
        for (int i = 1; i < 5; i++) begin
            repeat (4) @(negedge clk);
            check($sformatf("col_rot_%0d", i), int'(col_n), int'(exp_col[i]));
        end

        for (int i = 0; i < t; i++) begin
            press(tbl[i].row, tbl[i].col, tbl[i].hold, 30);
            check($sformatf("vec%0d_nwr", i), got.size(), tbl[i].n_wr);
            if (tbl[i].n_wr == 1 && got.size() > 0) begin
                check($sformatf("vec%0d_dig", i), int'(got[0][7:4]), tbl[i].dig);
                check($sformatf("vec%0d_pos", i), int'(got[0][3:0]), tbl[i].pos);
            end else if (tbl[i].n_wr == 8 && got.size() == 8) begin
                for (int j = 0; j < 8; j++) begin
                    check($sformatf("clr_dig%0d", j), int'(got[j][7:4]), 0);
                    check($sformatf("clr_pos%0d", j), int'(got[j][3:0]), j);
                end
            end
            check($sformatf("vec%0d_cursor", i), int'(pos), tbl[i].cur);
        end

        // Key '7' low for a single debounce sample only.
        got.delete();
        wait_col0(ok);
        check("bounce_col0_wait", int'(ok), 1);
        keys[8] = 1'b1;
        repeat (5) @(negedge clk);
        keys = 16'h0;
        repeat (4) @(negedge clk);
        check("bounce_scan_resumed", int'(col_n), 13);
        repeat (30) @(negedge clk);
        check("bounce_nwr", got.size(), 0);

        // '7' glitches to '8' mid-debounce; only the stable '8' may write.
        got.delete();
        wait_col0(ok);
        check("glitch_col0_wait", int'(ok), 1);
        keys[8] = 1'b1;
        repeat (5) @(negedge clk);
        keys = 16'h0;
        keys[9] = 1'b1;
        repeat (40) @(negedge clk);
        keys = 16'h0;
        repeat (30) @(negedge clk);
        check("glitch_nwr", got.size(), 1);
        if (got.size() > 0) begin
            check("glitch_dig", int'(got[0][7:4]), 8);
            check("glitch_pos", int'(got[0][3:0]), 5);
        end

        // Rows 0 and 2 both low in column 0: row 0 ('1') wins.
        keys = 16'h0;
        got.delete();
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        repeat (40) @(negedge clk);
        keys = 16'h0;
        repeat (30) @(negedge clk);
        check("prio_nwr", got.size(), 1);
        if (got.size() > 0) begin
            check("prio_dig", int'(got[0][7:4]), 1);
            check("prio_pos", int'(got[0][3:0]), 6);
        end

        // Reset in the middle of a clear burst.
        keys = 16'h0;
        keys[3] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (wr && pos == 4'd4) found = 1'b1;
        end
        check("clear_reached_pos4", int'(found), 1);
        #2;
        reset = 1'b1;
        keys  = 16'h0;
        #1;
        check("midclr_col_n", int'(col_n), 14);
        check("midclr_dig", int'(dig), 15);
        check("midclr_pos", int'(pos), 0);
        check("midclr_wr", int'(wr), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        got.delete();
        repeat (30) @(negedge clk);
        check("midclr_no_writes", got.size(), 0);

        // Random presses against a cursor/write model.
        cur = 0;
        for (int n = 0; n < 12; n++) begin
            k    = int'($urandom_range(0, 15));
            code = keymap[k];
            exp_q.delete();
            if (code < 10) begin
                exp_q.push_back(8'(code * 16 + cur));
                cur = (cur + 1) % 8;
            end else if (code == 15) begin
                cur = (cur + 7) % 8;
            end else if (code == 14) begin
                cur = 0;
            end else if (code == 10) begin
                for (int j = 0; j < 8; j++) exp_q.push_back(8'(j));
                cur = 0;
            end
            press(k / 4, k % 4, int'($urandom_range(40, 60)), int'($urandom_range(30, 40)));
            nw = got.size();
            check($sformatf("rnd%0d_key%0d_nwr", n, code), nw, exp_q.size());
            for (int j = 0; j < exp_q.size() && j < nw; j++) begin
                check($sformatf("rnd%0d_wr%0d", n, j), int'(got[j]), int'(exp_q[j]));
            end
            check($sformatf("rnd%0d_cursor", n), int'(pos), cur);
        end

        check("output_invariants", inv_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
